// File: rtl/axi_w_responder.sv
// AXI4 write-channel slave model: one AW burst at a time, W beats into a strobed word memory, B response.
// Optional macro AXI_W_BACKPRESSURE_EN throttles w_ready to every other DATA cycle.
module axi_w_responder #(
  parameter int MEM_DEPTH = 16,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      aw_addr,
  input  logic [7:0]       aw_len,
  input  logic             aw_valid,
  output logic             aw_ready,
  input  logic [31:0]      w_data,
  input  logic [3:0]       w_strb,
  input  logic             w_last,
  input  logic             w_valid,
  output logic             w_ready,
  output logic [1:0]       b_resp,
  output logic             b_valid,
  input  logic             b_ready,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [31:0]      dbg_data
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH) << 2;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] start_q, start_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             decerr_q, decerr_d;
  logic             slverr_q, slverr_d;
  logic [1:0]       b_resp_q, b_resp_d;
  logic [31:0]      mem_q [MEM_DEPTH];

  logic             aw_fire, w_fire, last_beat, beat_err, wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^aw_addr[1:0];

  assign aw_ready = (state_q == IDLE);
  assign b_valid  = (state_q == RESP);
  assign b_resp   = b_resp_q;
  assign dbg_data = mem_q[dbg_idx];

`ifdef AXI_W_BACKPRESSURE_EN
  // Zero on the first DATA cycle because it is held clear outside DATA.
  logic tog_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                tog_q <= 1'b0;
    else if (state_q != DATA)  tog_q <= 1'b0;
    else                       tog_q <= ~tog_q;
  end
  assign w_ready = (state_q == DATA) & tog_q;
`else
  assign w_ready = (state_q == DATA);
`endif

  assign aw_fire   = aw_valid & aw_ready;
  assign w_fire    = w_valid & w_ready;
  assign last_beat = (cnt_q == len_q);
  assign beat_err  = (w_last != last_beat);
  assign wr_en     = w_fire & ~decerr_q;
  // Word index wraps naturally at IDX_W bits.
  assign wr_idx    = start_q + IDX_W'(cnt_q);

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    decerr_d = decerr_q;
    slverr_d = slverr_q;
    b_resp_d = b_resp_q;
    case (state_q)
      IDLE: begin
        if (aw_fire) begin
          start_d  = aw_addr[IDX_W+1:2];
          len_d    = aw_len;
          cnt_d    = 8'd0;
          decerr_d = (aw_addr >= MEM_BYTES);
          slverr_d = 1'b0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (w_fire) begin
          cnt_d = cnt_q + 8'd1;
          if (beat_err) slverr_d = 1'b1;
          if (last_beat || w_last) begin
            state_d  = RESP;
            b_resp_d = decerr_q              ? 2'b11 :
                       (slverr_q || beat_err) ? 2'b10 : 2'b00;
          end
        end
      end
      RESP: begin
        if (b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      start_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      decerr_q <= 1'b0;
      slverr_q <= 1'b0;
      b_resp_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      decerr_q <= decerr_d;
      slverr_q <= slverr_d;
      b_resp_q <= b_resp_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < MEM_DEPTH; w++) mem_q[w] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (w_strb[b]) mem_q[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axi_w_responder.sv
// Directed bench for axi_w_responder: table of bursts with hand-computed responses and memory words,
// plus sequences for idle W traffic and mid-burst reset.
module tb_axi_w_responder;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic        aw_valid, aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last, w_valid, w_ready;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic [3:0]  dbg_idx;
  logic [31:0] dbg_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_w_responder #(.MEM_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    int               nb;
    logic [3:0][31:0] data;
    logic [3:0][3:0]  strb;
    logic [3:0]       lastm;
    int               gap;
    int               hold;
    logic [1:0]       resp;
    logic [3:0][3:0]  ci;
    logic [3:0][31:0] cv;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v, input int id);
    int n;
    @(negedge clk);
    aw_addr = v.addr; aw_len = v.len; aw_valid = 1'b1;
    n = 0;
    while (!aw_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk($sformatf("v%0d_aw_timeout", id), 32'd1, 32'd0);
    @(posedge clk); #1 aw_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_aw_ready_after_aw", id), 32'(aw_ready), 32'd0);
`ifndef AXI_W_BACKPRESSURE_EN
    chk($sformatf("v%0d_w_ready_after_aw", id), 32'(w_ready), 32'd1);
`endif
    for (int b = 0; b < v.nb; b++) begin
      if (b != 0) begin
        repeat (v.gap) @(negedge clk);
        @(negedge clk);
      end
      w_data = v.data[b]; w_strb = v.strb[b]; w_last = v.lastm[b]; w_valid = 1'b1;
      n = 0;
      while (!w_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk($sformatf("v%0d_w_timeout", id), 32'd1, 32'd0);
      @(posedge clk); #1 w_valid = 1'b0; w_last = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("v%0d_b_valid", id), 32'(b_valid), 32'd1);
    chk($sformatf("v%0d_b_resp", id), 32'(b_resp), 32'(v.resp));
    chk($sformatf("v%0d_w_ready_resp", id), 32'(w_ready), 32'd0);
    // aw_valid during RESP must not be captured
    for (int h = 0; h < v.hold; h++) begin
      aw_addr = 32'h20; aw_len = 8'd0; aw_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_hold%0d_b_valid", id, h), 32'(b_valid), 32'd1);
      chk($sformatf("v%0d_hold%0d_b_resp", id, h), 32'(b_resp), 32'(v.resp));
      chk($sformatf("v%0d_hold%0d_aw_ready", id, h), 32'(aw_ready), 32'd0);
    end
    aw_valid = 1'b0;
    b_ready = 1'b1;
    @(posedge clk); #1 b_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_aw_ready_after_b", id), 32'(aw_ready), 32'd1);
    chk($sformatf("v%0d_b_valid_after_b", id), 32'(b_valid), 32'd0);
    chk($sformatf("v%0d_w_ready_after_b", id), 32'(w_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      dbg_idx = v.ci[k];
      #1 chk($sformatf("v%0d_mem%0d", id, v.ci[k]), dbg_data, v.cv[k]);
    end
  endtask

  initial begin
    int n;
    vt[0] = '{32'h8, 8'd0, 1, {96'h0, 32'hAABBCCDD}, {12'h0, 4'h5}, 4'b0001, 0, 0, 2'b00,
              {4'd0, 4'd1, 4'd3, 4'd2}, {32'h0, 32'h0, 32'h0, 32'h00BB00DD}};
    vt[1] = '{32'h0, 8'd3, 4, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'hFFFF,
              4'b1000, 0, 5, 2'b00, {4'd3, 4'd2, 4'd1, 4'd0},
              {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}};
    vt[2] = '{32'h14, 8'd1, 2, {64'h0, 32'h9ABCDEF0, 32'h12345678}, {8'h0, 4'hC, 4'h3}, 4'b0010,
              2, 1, 2'b00, {4'd7, 4'd4, 4'd6, 4'd5}, {32'h0, 32'h0, 32'h9ABC0000, 32'h00005678}};
    vt[3] = '{32'h0, 8'd3, 2, {64'h0, 32'hB, 32'hA}, 16'h00FF, 4'b0010, 0, 0, 2'b10,
              {4'd3, 4'd2, 4'd1, 4'd0}, {32'h44444444, 32'h33333333, 32'hB, 32'hA}};
    vt[4] = '{32'h3C, 8'd1, 2, {64'h0, 32'h6, 32'h5}, 16'h00FF, 4'b0000, 1, 2, 2'b10,
              {4'd14, 4'd1, 4'd0, 4'd15}, {32'h0, 32'hB, 32'h6, 32'h5}};
    vt[5] = '{32'h40, 8'd1, 2, {64'h0, 32'h88, 32'h77}, 16'h00FF, 4'b0010, 0, 0, 2'b11,
              {4'd2, 4'd15, 4'd1, 4'd0}, {32'h33333333, 32'h5, 32'hB, 32'h6}};
    vt[6] = '{32'hFFFFFFF0, 8'd0, 1, {96'h0, 32'h99}, 16'h000F, 4'b0001, 0, 3, 2'b11,
              {4'd3, 4'd15, 4'd0, 4'd12}, {32'h44444444, 32'h5, 32'h6, 32'h0}};

    reset = 1'b0; aw_addr = '0; aw_len = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; dbg_idx = '0;
    #1;
    chk("rst_aw_ready", 32'(aw_ready), 32'd1);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_b_resp", 32'(b_resp), 32'd0);
    chk("rst_mem0", dbg_data, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_burst(vt[i], i);

    // W traffic while idle must be ignored
    @(negedge clk);
    w_data = 32'hFFFFFFFF; w_strb = 4'hF; w_last = 1'b1; w_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("idle_w_ready%0d", c), 32'(w_ready), 32'd0);
    end
    w_valid = 1'b0; w_last = 1'b0;
    dbg_idx = 4'd0; #1 chk("idle_w_mem0", dbg_data, 32'h6);
    dbg_idx = 4'd1; #1 chk("idle_w_mem1", dbg_data, 32'hB);

    // Reset in the middle of a 4-beat burst
    @(negedge clk);
    aw_addr = 32'h0; aw_len = 8'd3; aw_valid = 1'b1;
    @(posedge clk); #1 aw_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      w_data = 32'hDEAD0000 + 32'(b); w_strb = 4'hF; w_valid = 1'b1;
      n = 0;
      while (!w_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("mid_rst_w_timeout", 32'd1, 32'd0);
      @(posedge clk); #1 w_valid = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_b_valid", 32'(b_valid), 32'd0);
    chk("mid_rst_w_ready", 32'(w_ready), 32'd0);
    chk("mid_rst_aw_ready", 32'(aw_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < D; k++) begin
      dbg_idx = 4'(k);
      #1 chk($sformatf("mid_rst_mem%0d", k), dbg_data, 32'd0);
    end
    @(negedge clk);
    chk("post_rst_aw_ready", 32'(aw_ready), 32'd1);
    chk("post_rst_b_valid", 32'(b_valid), 32'd0);

    run_burst(vt[0], 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi_w_responder.md
Name: axi_w_responder

Overview:
- Slave-side AXI4 write responder for the VIP; the receiving end of the W channel that the W-channel monitor observes.
- Accepts one AW burst at a time, sinks W beats into a small internal word memory with byte strobes, validates WLAST placement, returns a B response.
- Used as the DUT-facing slave model in W/B channel tests.

Parameters:
- MEM_DEPTH, 16, number of 32-bit words in the internal memory (power of 2, >=2).
- IDX_W, $clog2(MEM_DEPTH), word index width (derived).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- aw_addr  input  32  burst start byte address; bits [1:0] ignored.
- aw_len  input  8  beats minus 1 (AXI4 INCR only).
- aw_valid  input  1  AW valid.
- aw_ready  output  1  AW ready.
- w_data  input  32  write data.
- w_strb  input  4  byte strobes; bit i enables byte i.
- w_last  input  1  last beat marker.
- w_valid  input  1  W valid.
- w_ready  output  1  W ready.
- b_resp  output  2  write response: 00 OKAY, 10 SLVERR, 11 DECERR.
- b_valid  output  1  B valid.
- b_ready  input  1  B ready.
- dbg_idx  input  IDX_W  memory word index for bench readback.
- dbg_data  output  32  combinational read of mem[dbg_idx].

Behaviour:
- FSM states: IDLE, DATA, RESP. State, counters and memory reset asynchronously when reset=0: state=IDLE, all mem words=0, beat_cnt=0, err flags=0.
- Outputs decoded from registered state only: aw_ready=(IDLE), w_ready=(DATA), b_valid=(RESP). b_resp is registered, resets to 00. During reset: aw_ready=1, w_ready=0, b_valid=0.
- IDLE: on aw_valid&aw_ready capture start_word=aw_addr[31:2], len=aw_len, beat_cnt=0; set decerr=(aw_addr >= MEM_DEPTH*4); clear slverr; go to DATA. w_ready is high from the next cycle.
- DATA, per accepted beat (w_valid&w_ready):
  - If !decerr, write each byte i with w_strb[i]=1 into mem[(start_word+beat_cnt) mod MEM_DEPTH]. Bytes with strobe 0 are unchanged. Index wraps modulo MEM_DEPTH.
  - beat_cnt increments (8 bits).
  - If beat_cnt==len, or w_last=1: go to RESP on the same edge.
  - slverr is set if w_last != (beat_cnt==len) on that beat. This covers an early last, which ends the burst early, and a missing last on the final beat.
- RESP: b_valid=1; b_resp = 11 if decerr, else 10 if slverr, else 00 (DECERR takes priority). b_resp is loaded on the DATA->RESP edge and held stable until b_valid&b_ready, then the FSM returns to IDLE.
- Latency:
  - AW handshake at edge N: w_ready=1 after N.
  - Final beat at edge M: b_valid=1 after M.
  - B handshake at edge K: aw_ready=1 after K.
- Boundary cases:
  - aw_valid outside IDLE is ignored; the burst is not captured.
  - w_valid in IDLE/RESP is not accepted and no write occurs.
  - w_valid low in DATA is a wait state; counters hold.
  - len=0 is a single-beat burst.
  - Reset asserted mid-burst or in RESP aborts immediately: no B is issued, memory is cleared, and the FSM is in IDLE on release.

Optional Feature:
- Macro AXI_W_BACKPRESSURE_EN.
- Defined: a toggle flop clears on entry to DATA and inverts every cycle in DATA. w_ready=(DATA)&toggle, so the first DATA cycle has w_ready=0 and then alternates. Beats are accepted only when w_ready=1.
- Undefined: the toggle logic is absent and w_ready=(DATA) continuously.
- All other behaviour is identical either way.

Test Plan:
- Basic burst: AW addr 0x0, len 3; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, strb F, last on 4th beat. Required: mem[0..3] equal those values; b_valid the cycle after the 4th beat with b_resp=00; aw_ready=1 after the B handshake.
- Partial strobe: mem[2]=0; AW addr 0x8, len 0; data 0xAABBCCDD, strb 0101, last=1. Required: mem[2]=0x00BB00DD, b_resp=00.
- Early last: AW addr 0x0, len 3; w_last=1 on beat 2 (data 0xA, 0xB). Required: RESP after beat 2, b_resp=10, mem[0]=0xA, mem[1]=0xB, mem[2..3] unchanged.
- Missing last plus wrap: AW addr 0x3C, len 1; two beats 0x5, 0x6 with w_last=0. Required: mem[15]=0x5, mem[0]=0x6, b_resp=10.
- Decode error: AW addr 0x40, len 1; two beats, last correct. Required: no memory change, b_resp=11.
- Backpressure and reset:
  - Hold b_ready=0 for 5 cycles in RESP. Required: b_valid and b_resp stable, aw_ready=0.
  - Separately, assert reset after 2 of 4 beats. Required: b_valid=0, w_ready=0, aw_ready=1, dbg_data=0 for all indices.
